// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV64I fields and an immediate into a 32-bit
// instruction word. Results go through a 2-entry FIFO, each tagged with an
// immediate-range error flag.
// Optional feature macro: INSTR_ENC_RANGE_CHECK_EN enables immediate range
// checking, NOP substitution on range errors, out_err and err_count.
module instr_encoder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [7:0]  err_count
);

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned CNT_W   = 8;

  localparam logic [2:0] FMT_R     = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_SHIFT = 3'd2;
  localparam logic [2:0] FMT_S     = 3'd3;
  localparam logic [2:0] FMT_SB    = 3'd4;
  localparam logic [2:0] FMT_U     = 3'd5;

  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0013;
  localparam logic [CNT_W-1:0]   CNT_MAX  = 8'hFF;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               err;
  } entry_t;

  // Encoder signals
  logic [INSTR_W-1:0] enc_c;
  logic               illegal_c;
  logic               range_bad_c;
  entry_t             word_c;

  // FIFO state
  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  logic       push_c;
  logic       pop_c;
  logic [1:0] count_nxt_c;
  logic       rd_ptr_nxt_c;
  entry_t     head_nxt_c;

  // Field placement for each legal format
  always_comb begin
    enc_c     = NOP_WORD;
    illegal_c = 1'b0;
    case (fmt)
      FMT_R:     enc_c = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I:     enc_c = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_SHIFT: enc_c = {funct7[6:1], imm[5:0], rs1, funct3, rd, opcode};
      FMT_S:     enc_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_SB:    enc_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U:     enc_c = {imm[31:12], rd, opcode};
      default:   illegal_c = 1'b1;
    endcase
  end

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam logic signed [63:0] I_MIN  = -64'sd2048;
  localparam logic signed [63:0] I_MAX  = 64'sd2047;
  localparam logic signed [63:0] SH_MAX = 64'sd63;
  localparam logic signed [63:0] SB_MIN = -64'sd4096;
  localparam logic signed [63:0] SB_MAX = 64'sd4094;
  localparam logic signed [63:0] U_MIN  = -64'sd2147483648;
  localparam logic signed [63:0] U_MAX  = 64'sd2147483647;

  logic signed [63:0] imm_s;
  assign imm_s = $signed(imm);

  // Signed range check of the immediate against its format's field
  always_comb begin
    range_bad_c = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad_c = (imm_s < I_MIN) || (imm_s > I_MAX);
      FMT_SHIFT:    range_bad_c = (imm_s < 64'sd0) || (imm_s > SH_MAX);
      FMT_SB:       range_bad_c = (imm_s < SB_MIN) || (imm_s > SB_MAX) || imm[0];
      FMT_U:        range_bad_c = (imm[11:0] != 12'd0) || (imm_s < U_MIN) || (imm_s > U_MAX);
      default:      range_bad_c = 1'b0;
    endcase
  end

  // Substitute a NOP for any erroneous request
  always_comb begin
    word_c.instr = enc_c;
    word_c.err   = 1'b0;
    if (illegal_c || range_bad_c) begin
      word_c.instr = NOP_WORD;
      word_c.err   = 1'b1;
    end
  end
`else
  // Upper immediate bits only matter to the range check
  logic unused_imm_hi;
  assign unused_imm_hi = ^imm[63:32];
  assign range_bad_c   = 1'b0;

  // Without range checking only an illegal format forces a NOP
  always_comb begin
    word_c.instr = illegal_c ? NOP_WORD : enc_c;
    word_c.err   = 1'b0;
  end
`endif

  assign push_c       = in_valid && in_ready;
  assign pop_c        = out_valid && out_ready;
  assign count_nxt_c  = count_q + 2'(push_c) - 2'(pop_c);
  assign rd_ptr_nxt_c = rd_ptr_q ^ pop_c;

  // Next head word: a word being written to the next read slot bypasses memory
  always_comb begin
    head_nxt_c = mem_q[rd_ptr_nxt_c];
    if (push_c && (wr_ptr_q == rd_ptr_nxt_c)) begin
      head_nxt_c = word_c;
    end
  end

  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= word_c;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      rd_ptr_q <= rd_ptr_nxt_c;
      count_q  <= count_nxt_c;
    end
  end

  // Registered handshake flags and head outputs; head holds when empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else begin
      in_ready  <= (count_nxt_c != 2'd2);
      out_valid <= (count_nxt_c != 2'd0);
      if (count_nxt_c != 2'd0) begin
        out_instr <= head_nxt_c.instr;
        out_err   <= head_nxt_c.err;
      end
    end
  end

  // Saturating count of accepted erroneous requests
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if (push_c && word_c.err && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodings, backpressure,
// reset and error saturation, then randomized traffic against a queue model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_count;

  instr_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

`ifdef INSTR_ENC_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    bit          err;
  } exp_t;

  exp_t q[$];
  int   model_cnt = 0;
  int   n_checks  = 0;
  int   n_errors  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: place fields per format, check immediate ranges as integers
  function automatic exp_t model(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                                 input logic [4:0] s2, input logic [63:0] im);
    exp_t   e;
    longint v;
    bit     bad;
    logic [31:0] w;
    v   = $signed(im);
    bad = 1'b0;
    w   = 32'h13;
    case (f)
      3'd0: w = {f7, s2, s1, f3, d, op};
      3'd1: begin w = {im[11:0], s1, f3, d, op}; bad = (v < -2048) || (v > 2047); end
      3'd2: begin w = {f7[6:1], im[5:0], s1, f3, d, op}; bad = (v < 0) || (v > 63); end
      3'd3: begin w = {im[11:5], s2, s1, f3, im[4:0], op}; bad = (v < -2048) || (v > 2047); end
      3'd4: begin
        w   = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], op};
        bad = (v < -4096) || (v > 4094) || (v % 2 != 0);
      end
      3'd5: begin
        w   = {im[31:12], d, op};
        bad = (v % 4096 != 0) || (v < -(64'sd1 <<< 31)) || (v > (64'sd1 <<< 31) - 1);
      end
      default: begin
        e.word = 32'h13;
        e.err  = CHK_EN;
        return e;
      end
    endcase
    if (CHK_EN && bad) begin
      e.word = 32'h13;
      e.err  = 1'b1;
    end else begin
      e.word = w;
      e.err  = 1'b0;
    end
    return e;
  endfunction

  // One cycle: check outputs against the model, drive new inputs, advance model
  task automatic step(input bit iv, input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [63:0] im, input bit ordy,
                      input bit use_exp, input logic [31:0] ew, input bit ee);
    exp_t e;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(q.size() != 0));
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("err_count", 64'(err_count), 64'(model_cnt));
    if (out_valid && q.size() != 0) begin
      check("out_instr", 64'(out_instr), 64'(q[0].word));
      check("out_err", 64'(out_err), 64'(q[0].err));
    end
    in_valid = iv; fmt = f; opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im; out_ready = ordy;
    if (out_valid && out_ready && q.size() != 0) void'(q.pop_front());
    if (in_valid && in_ready) begin
      if (use_exp) begin
        e.word = ew;
        e.err  = ee;
      end else begin
        e = model(f, op, f3, f7, d, s1, s2, im);
      end
      q.push_back(e);
      if (e.err && model_cnt < 255) model_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 64'd0, 1, 0, 0, 0);
  endtask

  // Random immediate biased toward field boundaries
  function automatic logic [63:0] rand_imm();
    logic [63:0] r;
    case ($urandom_range(0, 4))
      0: r = 64'(longint'($urandom_range(0, 10000)) - 5000);
      1: r = {$urandom, $urandom};
      2: r = 64'($urandom_range(0, 70)) - 64'd3;
      3: r = {{32{1'b0}}, $urandom} & ~64'hFFF;
      default: r = {{32{1'b1}}, $urandom} & ~64'(($urandom_range(0, 1)) ? 12'hFFF : 12'h000);
    endcase
    return r;
  endfunction

  initial begin
    reset_n = 1'b0; in_valid = 0; fmt = 0; opcode = 0; funct3 = 0; funct7 = 0;
    rd = 0; rs1 = 0; rs2 = 0; imm = 0; out_ready = 0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed encodings with spec constants
    step(1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 32'hFFF00093, 0);
    step(1, 3'd3, 7'h23, 3'd3, 7'd0, 5'd0, 5'd3, 5'd2, 64'd8, 1, 1, 32'h0021B423, 0);
    step(1, 3'd5, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5000, 1, 1, 32'h123452B7, 0);
    step(1, 3'd4, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -64'sd4, 1, 1, 32'hFE000EE3, 0);
    idle(2);

    // Error cases: unaligned branch, I out of range, illegal format
    if (CHK_EN) begin
      step(1, 3'd4, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd3, 1, 1, 32'h13, 1);
      step(1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd2048, 1, 1, 32'h13, 1);
    end else begin
      step(1, 3'd4, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd3, 1, 0, 0, 0);
      step(1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd2048, 1, 1, 32'h80000013, 0);
    end
    step(1, 3'd7, 7'h33, 3'd1, 7'd1, 5'd1, 5'd1, 5'd1, 64'd0, 1, 1, 32'h13, CHK_EN);
    idle(2);

    // Backpressure: three offers with the consumer stalled, then release
    step(1, 3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 64'd0, 0, 0, 0, 0);
    step(1, 3'd2, 7'h13, 3'd5, 7'h20, 5'd4, 5'd4, 5'd0, 64'd7, 0, 0, 0, 0);
    step(1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd9, 5'd8, 5'd0, 64'd100, 0, 0, 0, 0);
    step(1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd9, 5'd8, 5'd0, 64'd100, 0, 0, 0, 0);
    step(1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd9, 5'd8, 5'd0, 64'd100, 1, 0, 0, 0);
    step(1, 3'd1, 7'h13, 3'd0, 7'd0, 5'd9, 5'd8, 5'd0, 64'd100, 1, 0, 0, 0);
    idle(4);

    // Queue two erroneous words with consumer stalled, then reset mid-transfer
    step(1, 3'd6, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 0, 0, 0, 0);
    step(1, 3'd2, 7'h13, 3'd1, 7'd0, 5'd2, 5'd2, 5'd0, 64'd64, 0, 0, 0, 0);
    step(0, 3'd0, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 0, 0, 0, 0);
    @(negedge clk);
    check("pre_rst_err_count", 64'(err_count), 64'(CHK_EN ? 5 : 0));
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_err_count", 64'(err_count), 64'd0);
    q.delete();
    model_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 3'd5, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5000, 1, 1, 32'h123452B7, 0);
    idle(2);

    // Saturation of the error counter
    for (int i = 0; i < 300; i++) step(1, 3'd7, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 64'd0, 1, 0, 0, 0);
    idle(2);
    check("sat_err_count", 64'(err_count), 64'(CHK_EN ? 255 : 0));

    // Randomized traffic with random backpressure
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom),
           7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), rand_imm(),
           $urandom_range(0, 3) != 0, 0, 0, 0);
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
